// File: rtl/serial_uart_bridge.sv
// Processor-to-UART bridge: TX FIFO feeding a UART serialiser, and a UART
// deserialiser feeding an RX FIFO that the processor reads show-ahead.
module serial_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TX_AW        = 2,
  parameter int unsigned RX_AW        = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_data_in,
  input  logic       wren_in,
  output logic       ready_out,
  input  logic       rden_in,
  output logic [7:0] rd_data_out,
  output logic       valid_out,
  input  logic       uart_rxd_in,
  output logic       uart_txd_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned TX_DEPTH = 2 ** TX_AW;
  localparam int unsigned RX_DEPTH = 2 ** RX_AW;
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TX_AW:0] TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wp, tx_rp;
  logic         tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty  = (tx_wp == tx_rp);
  assign tx_full   = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                     (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign tx_push   = wren_in && !tx_full;
  assign ready_out = !tx_full;

  // TX FIFO pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_PTR_ONE;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= wr_data_in;
  end

  // ---------------- TX FSM ----------------
  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_bit_done;

  assign tx_bit_done = (tx_cnt == '0);
  // Pop when idle, or at the end of a stop bit so frames run back to back
  assign tx_pop = !tx_empty &&
                  ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_done));

  // Serialiser; the line is registered from the current state, one cycle behind it
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state     <= S_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      uart_txd_out <= 1'b1;
    end else begin
      case (tx_state)
        S_START: uart_txd_out <= 1'b0;
        S_DATA:  uart_txd_out <= tx_shift[0];
        default: uart_txd_out <= 1'b1;
      endcase
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state <= S_START;
            tx_cnt   <= BIT_RELOAD;
            tx_shift <= tx_mem[tx_rp[TX_AW-1:0]];
          end
        end
        S_START: begin
          if (tx_bit_done) begin
            tx_state <= S_DATA;
            tx_cnt   <= BIT_RELOAD;
            tx_bit   <= '0;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        S_DATA: begin
          if (tx_bit_done) begin
            tx_cnt   <= BIT_RELOAD;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) tx_state <= S_STOP;
            else                tx_bit   <= tx_bit + 3'd1;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        S_STOP: begin
          if (tx_bit_done) begin
            if (tx_pop) begin
              tx_state <= S_START;
              tx_cnt   <= BIT_RELOAD;
              tx_shift <= tx_mem[tx_rp[TX_AW-1:0]];
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX synchroniser ----------------
  logic rx_meta, rx_sync;

  // Two-flop synchroniser for the asynchronous receive line
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rxd_in;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wp, rx_rp;
  logic         rx_empty, rx_full, rx_push, rx_pop, rx_stop_ok;
  logic [7:0]   rx_shift;

  assign rx_empty    = (rx_wp == rx_rp);
  assign rx_full     = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                       (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
  assign rx_push     = rx_stop_ok && !rx_full;
  assign rx_pop      = rden_in && !rx_empty;
  assign valid_out   = !rx_empty;
  assign rd_data_out = rx_empty ? 8'h00 : rx_mem[rx_rp[RX_AW-1:0]];

  // RX FIFO pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_PTR_ONE;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_shift;
  end

  // ---------------- RX FSM ----------------
  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_mid;

  assign rx_mid     = (rx_cnt == '0);
  assign rx_stop_ok = (rx_state == S_STOP) && rx_mid && rx_sync;

  // Deserialiser sampling at bit midpoints, with error/overrun flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state         <= S_IDLE;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_frame_err_out <= (rx_state == S_STOP) && rx_mid && !rx_sync;
      if (rx_stop_ok && rx_full) rx_overrun_out <= 1'b1;
      case (rx_state)
        S_IDLE: begin
          if (!rx_sync) begin
            rx_state <= S_START;
            rx_cnt   <= HALF_BIT;
          end
        end
        S_START: begin
          if (rx_mid) begin
            if (rx_sync) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= BIT_RELOAD;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        S_DATA: begin
          if (rx_mid) begin
            rx_cnt   <= BIT_RELOAD;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        S_STOP: begin
          if (rx_mid) rx_state <= S_IDLE;
          else        rx_cnt   <= rx_cnt - CNT_ONE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge with scoreboard queues for TX and RX bytes.
module tb_serial_uart_bridge;

  localparam int unsigned CPB = 4;

  logic       clock;
  logic       reset;
  logic [7:0] wr_data_in;
  logic       wren_in;
  logic       ready_out;
  logic       rden_in;
  logic [7:0] rd_data_out;
  logic       valid_out;
  logic       uart_rxd_in;
  logic       uart_txd_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int          checks;
  int          errors;
  longint      cyc;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  bit          mon_busy;
  int          mon_t;
  logic [7:0]  mon_byte;
  longint      prev_start;
  bit          have_prev;
  bit          b2b_mode;
  int          fe_count;
  int          fe_before;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .TX_AW(2), .RX_AW(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .wr_data_in       (wr_data_in),
    .wren_in          (wren_in),
    .ready_out        (ready_out),
    .rden_in          (rden_in),
    .rd_data_out      (rd_data_out),
    .valid_out        (valid_out),
    .uart_rxd_in      (uart_rxd_in),
    .uart_txd_out     (uart_txd_out),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One UART frame on the rx line, CPB clocks per bit, changes on falling edges
  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    uart_rxd_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rxd_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rxd_in = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rxd_in = 1'b1;
  endtask

  // Check the head byte against the scoreboard, then pop it
  task automatic rx_pop_check(input string tag);
    logic [7:0] exp;
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_data"}, 32'(rd_data_out), 32'(exp));
    rden_in = 1'b1;
    @(negedge clock);
    rden_in = 1'b0;
  endtask

  initial begin
    cyc = 0;
    forever @(posedge clock) cyc++;
  end

  initial begin
    fe_count = 0;
    forever begin
      @(negedge clock);
      if (rx_frame_err_out) fe_count++;
    end
  end

  // TX line monitor: decode frames mid-bit and compare against the TX scoreboard
  initial begin
    mon_busy = 0;
    mon_t = 0;
    mon_byte = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_busy = 0;
      end else if (!mon_busy) begin
        if (uart_txd_out == 1'b0) begin
          mon_busy = 1;
          mon_t = 0;
          if (b2b_mode && have_prev)
            check("tx_frame_gap", 32'(cyc - prev_start), 32'(10 * CPB));
          prev_start = cyc;
          have_prev = 1;
        end
      end else begin
        mon_t++;
        if (mon_t == 2) begin
          check("tx_start_bit", 32'(uart_txd_out), 32'd0);
        end else if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0) begin
          mon_byte = {uart_txd_out, mon_byte[7:1]};
        end else if (mon_t == 38) begin
          check("tx_stop_bit", 32'(uart_txd_out), 32'd1);
          if (tx_q.size() > 0) begin
            check("tx_byte", 32'(mon_byte), 32'(tx_q.pop_front()));
          end else begin
            checks++;
            errors++;
            $error("FAIL tx_unexpected_frame: observed 0x%0h expected no frame", mon_byte);
          end
          mon_busy = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    have_prev = 0;
    b2b_mode = 0;
    prev_start = 0;
    reset = 1'b1;
    wren_in = 1'b0;
    rden_in = 1'b0;
    wr_data_in = 8'h00;
    uart_rxd_in = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_txd", 32'(uart_txd_out), 32'd1);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_rd_data", 32'(rd_data_out), 32'd0);
    check("rst_overrun", 32'(rx_overrun_out), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: single byte, start bit two edges after the write edge
    tx_q.push_back(8'hA5);
    wr_data_in = 8'hA5;
    wren_in = 1'b1;
    @(negedge clock);
    wren_in = 1'b0;
    check("t1_txd_edge0", 32'(uart_txd_out), 32'd1);
    @(negedge clock);
    check("t1_txd_edge1", 32'(uart_txd_out), 32'd1);
    @(negedge clock);
    check("t1_txd_edge2", 32'(uart_txd_out), 32'd0);
    repeat (45) @(negedge clock);
    check("t1_tx_drained", 32'(tx_q.size()), 32'd0);

    // 2: six back-to-back writes, the sixth hits a full FIFO
    have_prev = 0;
    b2b_mode = 1;
    for (int i = 0; i < 6; i++) begin
      wr_data_in = 8'(8'h10 + 8'(i * 17));
      wren_in = 1'b1;
      if (i < 5) tx_q.push_back(wr_data_in);
      @(negedge clock);
      if (i == 3) check("t2_ready_after4", 32'(ready_out), 32'd1);
      if (i == 4) check("t2_ready_after5", 32'(ready_out), 32'd0);
      if (i == 5) check("t2_ready_after6", 32'(ready_out), 32'd0);
    end
    wren_in = 1'b0;
    repeat (250) @(negedge clock);
    b2b_mode = 0;
    check("t2_tx_drained", 32'(tx_q.size()), 32'd0);
    check("t2_ready_idle", 32'(ready_out), 32'd1);

    // 3: single received byte
    rx_q.push_back(8'h3C);
    drive_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clock);
    rx_pop_check("t3_pop");
    check("t3_valid_after_pop", 32'(valid_out), 32'd0);
    check("t3_no_overrun", 32'(rx_overrun_out), 32'd0);

    // 4: five frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_q.push_back(8'(8'h61 + i));
      drive_rx(8'(8'h61 + i), 1'b1);
    end
    repeat (4) @(negedge clock);
    check("t4_overrun", 32'(rx_overrun_out), 32'd1);
    for (int i = 0; i < 4; i++) rx_pop_check("t4_pop");
    check("t4_empty", 32'(valid_out), 32'd0);

    // 5: glitch rejection and framing error
    uart_rxd_in = 1'b0;
    @(negedge clock);
    uart_rxd_in = 1'b1;
    repeat (10) @(negedge clock);
    check("t5_glitch_no_push", 32'(valid_out), 32'd0);
    fe_before = fe_count;
    drive_rx(8'h55, 1'b0);
    repeat (4) @(negedge clock);
    check("t5_frame_err_pulses", 32'(fe_count - fe_before), 32'd1);
    check("t5_frame_err_no_push", 32'(valid_out), 32'd0);
    check("t5_overrun_sticky", 32'(rx_overrun_out), 32'd1);

    // 6: reset mid TX frame with a byte waiting in RX
    drive_rx(8'h42, 1'b1);
    repeat (4) @(negedge clock);
    check("t6_rx_preload_valid", 32'(valid_out), 32'd1);
    check("t6_rx_preload_data", 32'(rd_data_out), 32'h42);
    wr_data_in = 8'h81;
    wren_in = 1'b1;
    @(negedge clock);
    wren_in = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rst_txd", 32'(uart_txd_out), 32'd1);
    check("t6_rst_ready", 32'(ready_out), 32'd1);
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_rd_data", 32'(rd_data_out), 32'd0);
    check("t6_rst_overrun", 32'(rx_overrun_out), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("t6_txd_stays_idle", 32'(uart_txd_out), 32'd1);

    // Pop while empty is ignored
    rden_in = 1'b1;
    @(negedge clock);
    rden_in = 1'b0;
    check("t6_empty_pop_valid", 32'(valid_out), 32'd0);
    check("t6_empty_pop_data", 32'(rd_data_out), 32'd0);

    // Push and pop on the same edge leave the count at one
    rx_q.push_back(8'h11);
    drive_rx(8'h11, 1'b1);
    repeat (4) @(negedge clock);
    rx_q.push_back(8'h22);
    drive_rx(8'h22, 1'b1);
    @(negedge clock);
    check("t6_pp_before_valid", 32'(valid_out), 32'd1);
    check("t6_pp_before_data", 32'(rd_data_out), 32'(rx_q.pop_front()));
    rden_in = 1'b1;
    @(negedge clock);
    rden_in = 1'b0;
    check("t6_pp_count_kept", 32'(valid_out), 32'd1);
    rx_pop_check("t6_pp_after");
    check("t6_pp_empty", 32'(valid_out), 32'd0);
    check("t6_rx_drained", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
